// File: rtl/weight_mem_ctrl_if.sv
// Signal bundle for weight_mem_ctrl: config load, stream control, weight-memory port and weight stream.
// The err signal exists only when WMC_LOAD_CHECK_EN is defined.
interface weight_mem_ctrl_if #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [dataWidth-1:0]    cfg_data;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    loaded;
    logic                    mem_wen;
    logic                    mem_ren;
    logic [addressWidth-1:0] mem_wadd;
    logic [addressWidth-1:0] mem_radd;
    logic [dataWidth-1:0]    mem_win;
    logic [dataWidth-1:0]    mem_wout;
    logic                    w_valid;
    logic                    w_ready;
    logic [dataWidth-1:0]    w_data;
    logic                    w_last;
`ifdef WMC_LOAD_CHECK_EN
    logic                    err;
`endif

    modport master (
        input  cfg_valid, cfg_data, start, mem_wout, w_ready,
        output cfg_ready, busy, done, loaded, mem_wen, mem_ren, mem_wadd, mem_radd,
        output mem_win, w_valid, w_data, w_last
`ifdef WMC_LOAD_CHECK_EN
        , output err
`endif
    );

    modport slave (
        output cfg_valid, cfg_data, start, mem_wout, w_ready,
        input  cfg_ready, busy, done, loaded, mem_wen, mem_ren, mem_wadd, mem_radd,
        input  mem_win, w_valid, w_data, w_last
`ifdef WMC_LOAD_CHECK_EN
        , input err
`endif
    );
endinterface

// File: rtl/weight_mem_ctrl.sv
// Weight memory controller: loads numWeight words into memory, then streams them to a neuron.
// Optional feature macro WMC_LOAD_CHECK_EN: refuse start until a full set is loaded, flag sticky err.
//   state | meaning
//   IDLE  | accepting cfg beats and start
//   RUN   | issuing reads for addresses 0..numWeight-1
//   DRAIN | all reads issued, waiting for the output FIFO to empty
module weight_mem_ctrl #(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    weight_mem_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    state_t                  r_state;
    logic [addressWidth-1:0] r_wptr;
    logic [addressWidth-1:0] r_rptr;
    logic                    r_loaded;
    logic                    r_done;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic [dataWidth-1:0]    r_fifo_data [2];
    logic [1:0]              r_fifo_last;
    logic                    r_fifo_rd;
    logic                    r_fifo_wr;
    logic [1:0]              r_occ;

    logic                    w_idle;
    logic                    w_cfg_acc;
    logic                    w_start_acc;
    logic                    w_fifo_nempty;
    logic                    w_valid_int;
    logic                    w_pop;
    logic                    w_pop_stored;
    logic                    w_push;
    logic                    w_ren;
    logic                    w_head_last;
    logic [dataWidth-1:0]    w_head_data;
    logic [2:0]              w_pending;
    logic [1:0]              w_occ_nxt;

    assign w_idle    = (r_state == IDLE);
    assign w_cfg_acc = bus.cfg_valid & w_idle;

`ifdef WMC_LOAD_CHECK_EN
    logic r_err;
    assign w_start_acc = bus.start & w_idle & r_loaded;
    assign bus.err     = r_err;
`else
    assign w_start_acc = bus.start & w_idle;
`endif

    // The word returning from memory counts as FIFO content in the cycle it is valid,
    // so the first word is visible one cycle after its read is issued.
    assign w_fifo_nempty = (r_occ != 2'd0);
    assign w_valid_int   = w_fifo_nempty | r_inflight;
    assign w_pop         = w_valid_int & bus.w_ready;
    assign w_pop_stored  = w_pop & w_fifo_nempty;
    assign w_push        = r_inflight & (w_fifo_nempty | ~w_pop);
    assign w_occ_nxt     = r_occ + {1'b0, w_push} - {1'b0, w_pop_stored};

    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_ren     = (r_state == RUN) && (w_pending < 3'd2);

    assign w_head_data = w_fifo_nempty ? r_fifo_data[r_fifo_rd] :
                         (r_inflight ? bus.mem_wout : '0);
    assign w_head_last = w_fifo_nempty ? r_fifo_last[r_fifo_rd] : r_inflight_last;

    assign bus.cfg_ready = w_idle;
    assign bus.busy      = ~w_idle;
    assign bus.done      = r_done;
    assign bus.loaded    = r_loaded;
    assign bus.mem_wen   = w_cfg_acc;
    assign bus.mem_wadd  = r_wptr;
    assign bus.mem_win   = bus.cfg_data;
    assign bus.mem_ren   = w_ren;
    assign bus.mem_radd  = r_rptr;
    assign bus.w_valid   = w_valid_int;
    assign bus.w_data    = w_head_data;
    assign bus.w_last    = w_valid_int & w_head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_loaded        <= 1'b0;
            r_done          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= 2'b00;
            r_fifo_rd       <= 1'b0;
            r_fifo_wr       <= 1'b0;
            r_occ           <= 2'd0;
`ifdef WMC_LOAD_CHECK_EN
            r_err           <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_cfg_acc) begin
                if (r_wptr == LAST_ADDR) begin
                    r_wptr   <= '0;
                    r_loaded <= 1'b1;
                end else begin
                    r_wptr <= r_wptr + addressWidth'(1);
                end
            end

            if (w_push) begin
                r_fifo_data[r_fifo_wr] <= bus.mem_wout;
                r_fifo_last[r_fifo_wr] <= r_inflight_last;
                r_fifo_wr              <= ~r_fifo_wr;
            end
            if (w_pop_stored) begin
                r_fifo_rd <= ~r_fifo_rd;
            end
            r_occ           <= w_occ_nxt;
            r_inflight      <= w_ren;
            r_inflight_last <= w_ren && (r_rptr == LAST_ADDR);

            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_state <= RUN;
                        r_rptr  <= '0;
                    end
                end
                RUN: begin
                    if (w_ren) begin
                        r_rptr <= r_rptr + addressWidth'(1);
                        if (r_rptr == LAST_ADDR) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_occ_nxt == 2'd0) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

`ifdef WMC_LOAD_CHECK_EN
            if (bus.start && w_idle && !r_loaded) begin
                r_err <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Scoreboard bench for weight_mem_ctrl: directed timing cases plus randomized load/stream rounds.
// Builds with or without WMC_LOAD_CHECK_EN; the load-check case adapts to the macro.
module tb_weight_mem_ctrl;
    localparam int NW = 3;
    localparam int AW = 10;
    localparam int DW = 16;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t          exp_q [$];
    logic [DW-1:0] m_mem [NW];
    int            m_wptr;
    bit            m_loaded;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    weight_mem_ctrl_if #(.addressWidth(AW), .dataWidth(DW)) bus ();

    weight_mem_ctrl #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after mem_ren.
    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_wadd] <= bus.mem_win;
        if (bus.mem_ren) bus.mem_wout <= mem[bus.mem_radd];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit start_ok();
`ifdef WMC_LOAD_CHECK_EN
        return m_loaded;
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_stream();
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back('{last: (i == NW - 1), data: m_mem[i]});
        end
    endtask

    // Every word presented and taken must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.w_valid && bus.w_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.w_data);
            end else begin
                e = exp_q.pop_front();
                check("w_data", bus.w_data, e.data);
                check("w_last", bus.w_last, e.last);
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 of the cycle after the beat.
    task automatic cfg_beat(input logic [DW-1:0] d, input bit with_start);
        bit ok;
        ok = with_start && start_ok();
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        bus.start     = with_start;
        @(negedge clk);
        check("mem_wen", bus.mem_wen, 1);
        check("mem_wadd", bus.mem_wadd, m_wptr);
        check("mem_win", bus.mem_win, d);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        m_mem[m_wptr] = d;
        m_wptr = (m_wptr + 1) % NW;
        if (m_wptr == 0) m_loaded = 1'b1;
        if (ok) push_stream();
    endtask

    task automatic start_pulse();
        bit ok;
        ok = start_ok();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (ok) push_stream();
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            @(posedge clk); #1;
            if (rnd) bus.w_ready = ($urandom_range(0, 3) != 0);
        end
        check("done_seen", got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_reads;
        bit  saw_done, saw_valid, saw_busy;
        rst_n         = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.start     = 1'b0;
        bus.w_ready   = 1'b1;
        m_wptr        = 0;
        m_loaded      = 1'b0;
        for (int i = 0; i < NW; i++) m_mem[i] = '0;

        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_w_valid", bus.w_valid, 0);
        check("rst_mem_ren", bus.mem_ren, 0);
        check("rst_done", bus.done, 0);
        check("rst_loaded", bus.loaded, 0);
`ifdef WMC_LOAD_CHECK_EN
        check("rst_err", bus.err, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cfg_ready", bus.cfg_ready, 1);
        check("post_rst_wadd", bus.mem_wadd, 0);
        @(posedge clk); #1;

        // Initial load of a full set
        cfg_beat(16'h0011, 1'b0);
        cfg_beat(16'h0022, 1'b0);
        @(negedge clk);
        check("loaded_before_third", bus.loaded, 0);
        @(posedge clk); #1;
        cfg_beat(16'h0033, 1'b0);
        @(negedge clk);
        check("loaded_after_third", bus.loaded, 1);
        check("wptr_wrapped", bus.mem_wadd, 0);
        @(posedge clk); #1;

        // Full-rate stream: cycle k is the interval ending at the k-th edge after start
        bus.w_ready = 1'b1;
        start_pulse();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("c1_mem_ren", bus.mem_ren, 1);
                check("c1_mem_radd", bus.mem_radd, 0);
                check("c1_w_valid", bus.w_valid, 0);
                check("c1_busy", bus.busy, 1);
            end
            if (k >= 2 && k <= 4) begin
                check("stream_valid", bus.w_valid, 1);
                check("stream_data", bus.w_data, m_mem[k-2]);
                check("stream_last", bus.w_last, (k == 4));
            end
            if (k == 5) begin
                check("c5_done", bus.done, 1);
                check("c5_w_valid", bus.w_valid, 0);
                check("c5_busy", bus.busy, 0);
            end
            if (k == 6) check("c6_done_clear", bus.done, 0);
            @(posedge clk); #1;
        end
        check("stream_all_taken", exp_q.size(), 0);

        // Back-pressure through cycles 2-5
        bus.w_ready = 1'b0;
        start_pulse();
        n_reads = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.mem_ren) n_reads++;
            if (k >= 2) begin
                check("stall_valid", bus.w_valid, 1);
                check("stall_data_held", bus.w_data, m_mem[0]);
            end
            @(posedge clk); #1;
        end
        check("stall_reads_le2", (n_reads <= 2), 1);
        bus.w_ready = 1'b1;
        wait_done(1'b0, 50);
        check("stall_all_taken", exp_q.size(), 0);

        // Start and a cfg beat in the same IDLE cycle
        cfg_beat(16'($urandom), 1'b1);
        @(negedge clk);
        check("co_busy", bus.busy, 1);
        @(posedge clk); #1;
        wait_done(1'b0, 50);
        check("co_all_taken", exp_q.size(), 0);
        check("co_loaded", bus.loaded, 1);

        // Randomized rounds with back-pressure and ignored starts
        for (int it = 0; it < 24; it++) begin
            int nb;
            bit co;
            nb = $urandom_range(0, 3);
            co = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) cfg_beat(16'($urandom), 1'b0);
            bus.w_ready = 1'($urandom_range(0, 1));
            if (co) cfg_beat(16'($urandom), 1'b1);
            else    start_pulse();
            @(negedge clk);
            check("rand_busy", bus.busy, 1);
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) begin
                bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            wait_done(1'b1, 200);
            @(negedge clk);
            check("rand_done_one_cycle", bus.done, 0);
            check("rand_all_taken", exp_q.size(), 0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a stream
        bus.w_ready = 1'b1;
        start_pulse();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        m_wptr   = 0;
        m_loaded = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_w_valid", bus.w_valid, 0);
        check("mid_rst_w_last", bus.w_last, 0);
        check("mid_rst_mem_ren", bus.mem_ren, 0);
        check("mid_rst_mem_wen", bus.mem_wen, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_loaded", bus.loaded, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("mid_rst_cfg_ready", bus.cfg_ready, 1);
        saw_done  = 1'b0;
        saw_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            saw_done  |= bus.done;
            saw_valid |= bus.w_valid;
            @(posedge clk); #1;
        end
        check("mid_rst_no_done", saw_done, 0);
        check("mid_rst_no_word", saw_valid, 0);

`ifdef WMC_LOAD_CHECK_EN
        // Start without a loaded set is refused and flagged
        start_pulse();
        saw_busy  = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            saw_busy  |= bus.busy;
            saw_valid |= bus.w_valid;
            @(posedge clk); #1;
        end
        check("nolaod_busy", saw_busy, 0);
        check("noload_no_word", saw_valid, 0);
        check("noload_err", bus.err, 1);
        for (int b = 0; b < NW; b++) cfg_beat(16'($urandom), 1'b0);
        check("err_sticky", bus.err, 1);
        start_pulse();
        wait_done(1'b0, 50);
        check("loaded_stream_taken", exp_q.size(), 0);
`else
        // Start without a loaded set streams the current memory contents
        start_pulse();
        @(negedge clk);
        check("noload_busy", bus.busy, 1);
        @(posedge clk); #1;
        wait_done(1'b0, 50);
        check("noload_all_taken", exp_q.size(), 0);
        check("noload_loaded", bus.loaded, 0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_mem_ctrl.md
WEIGHT_MEM_CTRL -- requirements
Module: weight_mem_ctrl

Interface
REQ-001 SHALL have parameter numWeight, default 3, meaning the number of weight words per neuron.
REQ-002 SHALL have parameter addressWidth, default 10, meaning the memory address width.
REQ-003 SHALL have parameter dataWidth, default 16, meaning the weight word width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid  input  1  weight-load beat valid.
REQ-007 SHALL have port cfg_ready  output  1  weight-load beat accepted when high with cfg_valid.
REQ-008 SHALL have port cfg_data  input  dataWidth  weight-load word.
REQ-009 SHALL have port start  input  1  single-cycle request to stream all weights.
REQ-010 SHALL have port busy  output  1  high while state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at stream completion.
REQ-012 SHALL have port loaded  output  1  high once a full set of numWeight words has been written.
REQ-013 SHALL have ports mem_wen/mem_ren  output  1  memory write/read enables.
REQ-014 SHALL have ports mem_wadd/mem_radd  output  addressWidth  memory write/read addresses.
REQ-015 SHALL have port mem_win  output  dataWidth  memory write data.
REQ-016 SHALL have port mem_wout  input  dataWidth  memory read data, valid one cycle after mem_ren.
REQ-017 SHALL have ports w_valid/w_ready  output/input  1  weight-stream handshake to the neuron.
REQ-018 SHALL have port w_data  output  dataWidth  streamed weight.
REQ-019 SHALL have port w_last  output  1  marks the word from address numWeight-1.

Function
REQ-020 SHALL implement states IDLE, RUN and DRAIN; IDLE->RUN on accepted start; RUN->DRAIN in the cycle the read of address numWeight-1 issues; DRAIN->IDLE when the FIFO is empty and no read is in flight.
REQ-021 SHALL drive cfg_ready = (state==IDLE), combinationally.
REQ-022 SHALL drive mem_wen = cfg_valid & cfg_ready, mem_wadd = wptr and mem_win = cfg_data.
REQ-023 SHALL increment wptr on each accepted beat, wrap it from numWeight-1 to 0 and set loaded on the wrap.
REQ-024 SHALL accept start only in IDLE; start in RUN or DRAIN is ignored.
REQ-025 SHALL accept both start and a cfg beat that arrive in the same IDLE cycle; the write completes before any read issues.
REQ-026 SHALL clear rptr on accepted start, then issue mem_ren with mem_radd = rptr and increment rptr on each issue, for addresses 0 to numWeight-1 exactly once each.
REQ-027 SHALL buffer returned words in a 2-entry output FIFO and issue a read only when (occupancy + in-flight - pop this cycle) < 2.
REQ-028 SHALL drive w_valid = FIFO non-empty and w_data = FIFO head, and pop on w_valid & w_ready.
REQ-029 SHALL sustain one word per cycle when w_ready is held high.
REQ-030 SHALL make the first w_valid occur 2 cycles after the start edge (start at edge 0, mem_ren in cycle 1, w_valid in cycle 2).
REQ-031 SHALL hold w_data stable while w_valid is high and w_ready is low, and SHALL never drop or duplicate a word.
REQ-032 SHALL pulse done for one cycle on the DRAIN->IDLE transition.
REQ-033 SHALL assert w_last only with the final word.

Reset
REQ-034 SHALL, on rst_n low, immediately set state to IDLE and clear wptr, rptr, loaded, FIFO, in-flight flag, done, w_valid, w_last, mem_wen and mem_ren.
REQ-035 SHALL discard any in-progress stream on reset mid-operation and SHALL not produce a done pulse for it.
REQ-036 SHALL drive cfg_ready 1 in the first cycle after rst_n deasserts.

Configuration
REQ-037 SHALL, when WMC_LOAD_CHECK_EN is defined, ignore start while loaded==0 and set a sticky output err (1 bit, cleared only by reset).
REQ-038 SHALL, when WMC_LOAD_CHECK_EN is undefined, accept start regardless of loaded, omit the err port, and stream whatever the memory holds.

Verification
REQ-039 Verification SHALL cover: numWeight=3, cfg beats 0x0011, 0x0022, 0x0033 -> mem_wadd 0,1,2; loaded=1 after the third beat; wptr=0.
REQ-040 Verification SHALL cover: start with w_ready=1 -> w_data 0x0011, 0x0022, 0x0033 in cycles 2-4; w_last in cycle 4; done in cycle 5.
REQ-041 Verification SHALL cover: w_ready low cycles 2-5 -> at most 2 reads issued; w_data=0x0011 held; all 3 words delivered in order after release.
REQ-042 Verification SHALL cover: start and cfg_valid in the same IDLE cycle -> both accepted; the stream reflects the new word.
REQ-043 Verification SHALL cover: rst_n low during RUN -> all outputs 0 asynchronously; no done pulse; cfg_ready=1 after release.
REQ-044 Verification SHALL cover: with WMC_LOAD_CHECK_EN defined and no load, start -> busy stays 0 and err=1.
